// File: rtl/invader_formation_if.sv
// rtl/invader_formation_if.sv - shot inputs and formation outputs of invader_formation
interface invader_formation_if #(
  parameter int N = 24
);
  logic         frame_tick;
  logic         tiro_ativo_jogador;
  logic [9:0]   posX_Municao1;
  logic [9:0]   posY_Municao1;
  logic [9:0]   base_x;
  logic [9:0]   base_y;
  logic [N-1:0] vivo_mask;
  logic         colisao_inimigo;
  logic [4:0]   hit_index;
  logic         wave_cleared;
  logic         invaded;

  modport master (
    output frame_tick, tiro_ativo_jogador, posX_Municao1, posY_Municao1,
    input  base_x, base_y, vivo_mask, colisao_inimigo, hit_index, wave_cleared, invaded
  );

  modport slave (
    input  frame_tick, tiro_ativo_jogador, posX_Municao1, posY_Municao1,
    output base_x, base_y, vivo_mask, colisao_inimigo, hit_index, wave_cleared, invaded
  );
endinterface

// File: rtl/invader_formation.sv
// rtl/invader_formation.sv - enemy grid position, march pattern, alive mask and per-frame shot test
module invader_formation #(
  parameter int COLS     = 8,
  parameter int ROWS     = 3,
  parameter int DX       = 64,
  parameter int DY       = 50,
  parameter int INV_W    = 32,
  parameter int INV_H    = 24,
  parameter int X0       = 40,
  parameter int Y0       = 40,
  parameter int STEP_X   = 8,
  parameter int STEP_Y   = 16,
  parameter int X_MIN    = 8,
  parameter int X_MAX    = 632,
  parameter int Y_LIMIT  = 400,
  parameter int MOVE_DIV = 30
) (
  input  logic               clk,
  input  logic               reset,
  invader_formation_if.slave bus
);
  localparam int N = ROWS * COLS;

  typedef enum logic [2:0] {WAIT, SCAN, MOVE, CLEARED, INVADED} state_t;
  state_t state, state_nx;

  logic [9:0]   base_x, base_y, shot_x, shot_y, base_x_nx, base_y_nx;
  logic [N-1:0] vivo;
  logic         dir_left, scan_en, colisao, wave_cleared, invaded;
  logic [4:0]   scan_k, scan_col, scan_row, hit_index;
  logic [15:0]  div;

  logic [10:0]  box_x, box_y, sx, sy, right_edge;
  logic         hit, scan_last, step_down, div_wrap, low_edge;
  logic         latch_en, scan_adv, kill, do_move;

  // All geometry is evaluated at 11 bits so box edges never wrap.
  assign sx         = {1'b0, shot_x};
  assign sy         = {1'b0, shot_y};
  assign box_x      = {1'b0, base_x} + 11'(int'(scan_col) * DX);
  assign box_y      = {1'b0, base_y} + 11'(int'(scan_row) * DY);
  assign hit        = scan_en && vivo[scan_k] &&
                      (sx >= box_x) && (sx < box_x + 11'(INV_W)) &&
                      (sy >= box_y) && (sy < box_y + 11'(INV_H));
  assign scan_last  = (scan_k == 5'(N - 1));

  assign right_edge = {1'b0, base_x} + 11'(STEP_X + (COLS - 1) * DX + INV_W);
  assign div_wrap   = (div == 16'(MOVE_DIV - 1));
  assign step_down  = dir_left ? ({1'b0, base_x} < 11'(X_MIN + STEP_X))
                               : (right_edge > 11'(X_MAX));

  always_comb begin
    base_x_nx = base_x;
    base_y_nx = base_y;
    if (div_wrap) begin
      if (step_down)     base_y_nx = base_y + 10'(STEP_Y);
      else if (dir_left) base_x_nx = base_x - 10'(STEP_X);
      else               base_x_nx = base_x + 10'(STEP_X);
    end
  end

  // Invasion is judged on the post-step position.
  assign low_edge = ({1'b0, base_y_nx} + 11'((ROWS - 1) * DY + INV_H)) >= 11'(Y_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      WAIT:    if (bus.frame_tick) state_nx = SCAN;
      SCAN:    if (hit || scan_last) state_nx = MOVE;
      MOVE: begin
        if (vivo == '0)    state_nx = CLEARED;
        else if (low_edge) state_nx = INVADED;
        else               state_nx = WAIT;
      end
      default: state_nx = state;
    endcase
  end

  always_comb begin
    latch_en = (state == WAIT) && bus.frame_tick;
    scan_adv = (state == SCAN) && !hit;
    kill     = (state == SCAN) && hit;
    do_move  = (state == MOVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_x       <= 10'(X0);
      base_y       <= 10'(Y0);
      dir_left     <= 1'b0;
      div          <= '0;
      vivo         <= '1;
      colisao      <= 1'b0;
      hit_index    <= '0;
      wave_cleared <= 1'b0;
      invaded      <= 1'b0;
      shot_x       <= '0;
      shot_y       <= '0;
      scan_en      <= 1'b0;
      scan_k       <= '0;
      scan_col     <= '0;
      scan_row     <= '0;
    end else begin
      colisao <= 1'b0;
      if (latch_en) begin
        shot_x   <= bus.posX_Municao1;
        shot_y   <= bus.posY_Municao1;
        scan_en  <= bus.tiro_ativo_jogador;
        scan_k   <= '0;
        scan_col <= '0;
        scan_row <= '0;
      end
      if (scan_adv) begin
        scan_k <= scan_k + 5'd1;
        if (scan_col == 5'(COLS - 1)) begin
          scan_col <= '0;
          scan_row <= scan_row + 5'd1;
        end else begin
          scan_col <= scan_col + 5'd1;
        end
      end
      if (kill) begin
        vivo[scan_k] <= 1'b0;
        hit_index    <= scan_k;
        colisao      <= 1'b1;
      end
      if (do_move) begin
        div    <= div_wrap ? '0 : div + 16'd1;
        base_x <= base_x_nx;
        base_y <= base_y_nx;
        if (div_wrap && step_down) dir_left <= ~dir_left;
      end
      if (state == CLEARED) wave_cleared <= 1'b1;
      if (state == INVADED) invaded      <= 1'b1;
    end
  end

  assign bus.base_x          = base_x;
  assign bus.base_y          = base_y;
  assign bus.vivo_mask       = vivo;
  assign bus.colisao_inimigo = colisao;
  assign bus.hit_index       = hit_index;
  assign bus.wave_cleared    = wave_cleared;
  assign bus.invaded         = invaded;
endmodule

// File: tb/tb_invader_formation.sv
// tb/tb_invader_formation.sv - randomized bench for invader_formation against a frame-level model
module tb_invader_formation;
  localparam int MOVE_DIV = 1;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  invader_formation_if #(.N(24)) bus ();

  invader_formation #(.MOVE_DIV(MOVE_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Frame-level model of the formation.
  int          m_bx, m_by, m_dir_left, m_div, m_hidx, m_cleared, m_invaded;
  logic [23:0] m_mask;

  function automatic void model_reset();
    m_bx = 40; m_by = 40; m_dir_left = 0; m_div = 0; m_hidx = 0;
    m_cleared = 0; m_invaded = 0; m_mask = 24'hFFFFFF;
  endfunction

  function automatic int model_frame(input int sx, input int sy, input int act);
    int k;
    int x;
    int y;
    k = -1;
    if (m_cleared != 0 || m_invaded != 0) return -1;
    if (act != 0) begin
      for (int i = 0; i < 24; i++) begin
        x = m_bx + (i % 8) * 64;
        y = m_by + (i / 8) * 50;
        if (k < 0 && m_mask[i] && sx >= x && sx < x + 32 && sy >= y && sy < y + 24) k = i;
      end
    end
    if (k >= 0) begin
      m_mask[k] = 1'b0;
      m_hidx = k;
    end
    if (m_div == MOVE_DIV - 1) begin
      m_div = 0;
      if (m_dir_left == 0) begin
        if (m_bx + 8 + 7 * 64 + 32 > 632) begin m_by += 16; m_dir_left = 1; end
        else m_bx += 8;
      end else begin
        if (m_bx < 16) begin m_by += 16; m_dir_left = 0; end
        else m_bx -= 8;
      end
    end else begin
      m_div++;
    end
    if (m_mask == 24'd0) m_cleared = 1;
    else if (m_by + 100 + 24 >= 400) m_invaded = 1;
    return k;
  endfunction

  // Drivers; all called and returning just after (#1) a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_frame(input int sx, input int sy, input int act, input int extra,
                           input int scramble, output int pulses, output int pedge);
    bus.posX_Municao1      = 10'(sx);
    bus.posY_Municao1      = 10'(sy);
    bus.tiro_ativo_jogador = (act != 0);
    bus.frame_tick         = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = (extra != 0);
    if (scramble != 0) begin
      bus.posX_Municao1      = 10'($urandom_range(0, 639));
      bus.posY_Municao1      = 10'($urandom_range(0, 479));
      bus.tiro_ativo_jogador = 1'b1;
    end
    pulses = 0;
    pedge  = -1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (e == 1) bus.frame_tick = 1'b0;
      if (bus.colisao_inimigo) begin
        pulses++;
        if (pedge < 0) pedge = e;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (100) @(posedge clk);
    #1;
    checks += 7;
    if (bus.base_x !== 10'd40) begin failures++; $display("FAIL reset_base_x got=%0d exp=40", bus.base_x); end
    if (bus.base_y !== 10'd40) begin failures++; $display("FAIL reset_base_y got=%0d exp=40", bus.base_y); end
    if (bus.vivo_mask !== 24'hFFFFFF) begin failures++; $display("FAIL reset_mask got=%h exp=ffffff", bus.vivo_mask); end
    if (bus.colisao_inimigo !== 1'b0) begin failures++; $display("FAIL reset_colisao got=%b exp=0", bus.colisao_inimigo); end
    if (bus.hit_index !== 5'd0) begin failures++; $display("FAIL reset_hit_index got=%0d exp=0", bus.hit_index); end
    if (bus.wave_cleared !== 1'b0) begin failures++; $display("FAIL reset_cleared got=%b exp=0", bus.wave_cleared); end
    if (bus.invaded !== 1'b0) begin failures++; $display("FAIL reset_invaded got=%b exp=0", bus.invaded); end
  endtask

  task automatic test_march();
    int p;
    int e;
    do_reset();
    repeat (14) run_frame(0, 0, 0, 0, 0, p, e);
    checks += 2;
    if (bus.base_x !== 10'd152) begin failures++; $display("FAIL march14_x got=%0d exp=152", bus.base_x); end
    if (bus.base_y !== 10'd40) begin failures++; $display("FAIL march14_y got=%0d exp=40", bus.base_y); end
    run_frame(0, 0, 0, 0, 0, p, e);
    checks += 2;
    if (bus.base_x !== 10'd152) begin failures++; $display("FAIL march15_x got=%0d exp=152", bus.base_x); end
    if (bus.base_y !== 10'd56) begin failures++; $display("FAIL march15_y got=%0d exp=56", bus.base_y); end
    run_frame(0, 0, 0, 0, 0, p, e);
    checks += 2;
    if (bus.base_x !== 10'd144) begin failures++; $display("FAIL march16_x got=%0d exp=144", bus.base_x); end
    if (bus.base_y !== 10'd56) begin failures++; $display("FAIL march16_y got=%0d exp=56", bus.base_y); end
  endtask

  task automatic test_hit();
    int p;
    int e;
    do_reset();
    run_frame(72, 40, 1, 0, 0, p, e);
    checks += 2;
    if (p != 0) begin failures++; $display("FAIL gap_pulses got=%0d exp=0", p); end
    if (bus.vivo_mask !== 24'hFFFFFF) begin failures++; $display("FAIL gap_mask got=%h exp=ffffff", bus.vivo_mask); end
    do_reset();
    run_frame(173, 100, 1, 0, 0, p, e);
    checks += 4;
    if (p != 1) begin failures++; $display("FAIL hit_pulses got=%0d exp=1", p); end
    if (e != 11) begin failures++; $display("FAIL hit_latency got=%0d exp=11", e); end
    if (bus.hit_index !== 5'd10) begin failures++; $display("FAIL hit_index got=%0d exp=10", bus.hit_index); end
    if (bus.vivo_mask !== 24'hFFFBFF) begin failures++; $display("FAIL hit_mask got=%h exp=fffbff", bus.vivo_mask); end
  endtask

  task automatic test_disabled();
    int p;
    int e;
    do_reset();
    run_frame(240, 50, 0, 0, 0, p, e);
    checks += 2;
    if (p != 0) begin failures++; $display("FAIL disabled_pulses got=%0d exp=0", p); end
    if (bus.vivo_mask !== 24'hFFFFFF) begin failures++; $display("FAIL disabled_mask got=%h exp=ffffff", bus.vivo_mask); end
    // base_x is now 48, so x=240 sits exactly on enemy 3's left edge.
    run_frame(240, 50, 1, 0, 0, p, e);
    checks += 3;
    if (p != 1) begin failures++; $display("FAIL edge_pulses got=%0d exp=1", p); end
    if (e != 4) begin failures++; $display("FAIL edge_latency got=%0d exp=4", e); end
    if (bus.hit_index !== 5'd3) begin failures++; $display("FAIL edge_index got=%0d exp=3", bus.hit_index); end
  endtask

  task automatic test_random();
    int p;
    int e;
    int k;
    int sx;
    int sy;
    int act;
    int tgt;
    do_reset();
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 1) == 0) begin
        tgt = $urandom_range(0, 23);
        sx  = m_bx + (tgt % 8) * 64 + $urandom_range(0, 31);
        sy  = m_by + (tgt / 8) * 50 + $urandom_range(0, 23);
        if ($urandom_range(0, 3) == 0) sx = m_bx + (tgt % 8) * 64 + 32;
      end else begin
        sx = $urandom_range(0, 639);
        sy = $urandom_range(0, 479);
      end
      act = ($urandom_range(0, 3) != 0) ? 1 : 0;
      run_frame(sx, sy, act, $urandom_range(0, 1), $urandom_range(0, 1), p, e);
      k = model_frame(sx, sy, act);
      checks += 7;
      if (p != ((k >= 0) ? 1 : 0)) begin failures++; $display("FAIL rnd_pulses f=%0d got=%0d exp_k=%0d", f, p, k); end
      if (bus.hit_index !== 5'(m_hidx)) begin failures++; $display("FAIL rnd_index f=%0d got=%0d exp=%0d", f, bus.hit_index, m_hidx); end
      if (bus.vivo_mask !== m_mask) begin failures++; $display("FAIL rnd_mask f=%0d got=%h exp=%h", f, bus.vivo_mask, m_mask); end
      if (bus.base_x !== 10'(m_bx)) begin failures++; $display("FAIL rnd_base_x f=%0d got=%0d exp=%0d", f, bus.base_x, m_bx); end
      if (bus.base_y !== 10'(m_by)) begin failures++; $display("FAIL rnd_base_y f=%0d got=%0d exp=%0d", f, bus.base_y, m_by); end
      if (bus.wave_cleared !== 1'(m_cleared)) begin failures++; $display("FAIL rnd_cleared f=%0d got=%b exp=%0d", f, bus.wave_cleared, m_cleared); end
      if (bus.invaded !== 1'(m_invaded)) begin failures++; $display("FAIL rnd_invaded f=%0d got=%b exp=%0d", f, bus.invaded, m_invaded); end
      if (k >= 0) begin
        checks++;
        if (e != k + 1) begin failures++; $display("FAIL rnd_latency f=%0d got=%0d exp=%0d", f, e, k + 1); end
      end
    end
  endtask

  task automatic test_clear_all();
    int p;
    int e;
    int k;
    int total;
    int sx;
    int sy;
    int bx;
    int by;
    do_reset();
    total = 0;
    for (int i = 0; i < 24; i++) begin
      sx = m_bx + (i % 8) * 64 + 16;
      sy = m_by + (i / 8) * 50 + 12;
      run_frame(sx, sy, 1, 0, 0, p, e);
      k = model_frame(sx, sy, 1);
      total += p;
    end
    checks += 5;
    if (total != 24) begin failures++; $display("FAIL clear_pulses got=%0d exp=24", total); end
    if (bus.vivo_mask !== 24'd0) begin failures++; $display("FAIL clear_mask got=%h exp=0", bus.vivo_mask); end
    if (bus.wave_cleared !== 1'b1) begin failures++; $display("FAIL clear_flag got=%b exp=1", bus.wave_cleared); end
    if (bus.invaded !== 1'b0) begin failures++; $display("FAIL clear_invaded got=%b exp=0", bus.invaded); end
    if (bus.base_x !== 10'(m_bx)) begin failures++; $display("FAIL clear_base_x got=%0d exp=%0d", bus.base_x, m_bx); end
    bx = m_bx;
    by = m_by;
    total = 0;
    repeat (3) begin
      run_frame(173, 100, 1, 0, 0, p, e);
      total += p;
    end
    checks += 4;
    if (total != 0) begin failures++; $display("FAIL cleared_pulses got=%0d exp=0", total); end
    if (bus.base_x !== 10'(bx)) begin failures++; $display("FAIL cleared_hold_x got=%0d exp=%0d", bus.base_x, bx); end
    if (bus.base_y !== 10'(by)) begin failures++; $display("FAIL cleared_hold_y got=%0d exp=%0d", bus.base_y, by); end
    if (bus.wave_cleared !== 1'b1) begin failures++; $display("FAIL cleared_sticky got=%b exp=1", bus.wave_cleared); end
  endtask

  task automatic test_invade();
    int p;
    int e;
    int k;
    int n;
    do_reset();
    n = 0;
    while (m_invaded == 0 && n < 400) begin
      run_frame(0, 0, 0, 0, 0, p, e);
      k = model_frame(0, 0, 0);
      n++;
    end
    checks += 4;
    if (bus.invaded !== 1'b1) begin failures++; $display("FAIL invade_flag got=%b exp=1 frames=%0d", bus.invaded, n); end
    if (bus.base_y !== 10'd280) begin failures++; $display("FAIL invade_base_y got=%0d exp=280", bus.base_y); end
    if (bus.base_x !== 10'(m_bx)) begin failures++; $display("FAIL invade_base_x got=%0d exp=%0d", bus.base_x, m_bx); end
    if (bus.wave_cleared !== 1'b0) begin failures++; $display("FAIL invade_cleared got=%b exp=0", bus.wave_cleared); end
    run_frame(0, 0, 0, 0, 0, p, e);
    checks++;
    if (bus.base_y !== 10'd280) begin failures++; $display("FAIL invade_hold_y got=%0d exp=280", bus.base_y); end
  endtask

  task automatic test_reset_mid_scan();
    int p;
    int e;
    do_reset();
    bus.posX_Municao1      = 10'd173;
    bus.posY_Municao1      = 10'd100;
    bus.tiro_ativo_jogador = 1'b1;
    bus.frame_tick         = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks += 3;
    if (bus.vivo_mask !== 24'hFFFFFF) begin failures++; $display("FAIL midscan_mask got=%h exp=ffffff", bus.vivo_mask); end
    if (bus.colisao_inimigo !== 1'b0) begin failures++; $display("FAIL midscan_colisao got=%b exp=0", bus.colisao_inimigo); end
    if (bus.base_x !== 10'd40) begin failures++; $display("FAIL midscan_base_x got=%0d exp=40", bus.base_x); end
    p = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.colisao_inimigo) p++;
    end
    checks += 3;
    if (p != 0) begin failures++; $display("FAIL midscan_pulses got=%0d exp=0", p); end
    if (bus.vivo_mask !== 24'hFFFFFF) begin failures++; $display("FAIL midscan_mask_late got=%h exp=ffffff", bus.vivo_mask); end
    if (bus.base_x !== 10'd40) begin failures++; $display("FAIL midscan_base_x_late got=%0d exp=40", bus.base_x); end
    run_frame(173, 100, 1, 0, 0, p, e);
    checks += 2;
    if (e != 11) begin failures++; $display("FAIL midscan_rescan_latency got=%0d exp=11", e); end
    if (bus.hit_index !== 5'd10) begin failures++; $display("FAIL midscan_rescan_index got=%0d exp=10", bus.hit_index); end
  endtask

  initial begin
    clk                    = 1'b0;
    reset                  = 1'b1;
    checks                 = 0;
    failures               = 0;
    bus.frame_tick         = 1'b0;
    bus.tiro_ativo_jogador = 1'b0;
    bus.posX_Municao1      = '0;
    bus.posY_Municao1      = '0;
    model_reset();
    test_reset();
    test_march();
    test_hit();
    test_disabled();
    test_random();
    test_clear_all();
    test_invade();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
